cp0_exception_unit: RTL and testbench
=====================================

Name: cp0_exception_unit

Overview:
- Coprocessor-0 block for the single-cycle MIPS core.
- Produces the exception/return controls that the PC next-address logic consumes: HasExp and EPC.
- Consumes the PC of the current instruction, ERET, MTC0/MFC0 accesses, and the exception and interrupt sources.
- Holds the architectural Status(12), Cause(13), EPC(14) and PRId(15) registers.

Parameters:
- SYNC_STAGES, 2, flop stages on each ext_int line (legal 1..3).
- PRID_VALUE, 32'h00018000, constant value returned when PRId is read.
- STATUS_RESET, 32'h0000FC01, Status value at reset (IM[15:10]=all ones, IE=1, EXL=0).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- IsCOP0  in  1  current instruction is a COP0 op (MTC0/MFC0/ERET).
- Mtc0  in  1  write strobe; valid only with IsCOP0=1.
- IsEret  in  1  ERET executing; valid only with IsCOP0=1.
- RegAddr  in  5  CP0 register number (Instr[15:11]).
- WriteData  in  32  MTC0 source (rt value).
- PresentPC  in  32  PC of the instruction in execution.
- SyscallReq  in  1  SYSCALL decoded this cycle.
- OverflowReq  in  1  ALU signed overflow this cycle.
- ext_int  in  6  asynchronous level-sensitive hardware interrupt lines.
- HasExp  out  1  redirect fetch to the handler this cycle (combinational).
- EPC  out  32  EPC register, the ERET target.
- ReadData  out  32  MFC0 read data (combinational on RegAddr).
- Status  out  32  Status register (debug).
- Cause  out  32  Cause register (debug).

Behaviour:
- Reset, asynchronous: Status=STATUS_RESET; Cause=0; EPC=0; synchronizer flops=0; HasExp=0.
- Synchronizer: each ext_int bit passes through SYNC_STAGES flops. Every cycle, Cause.IP[15:10] <= synchronized value (pure sampling, no sticky latch).
- Pending interrupt: int_pend = Status.IE & ~Status.EXL & |(Cause.IP[15:10] & Status.IM[15:10]).
- HasExp = int_pend | (~Status.EXL & (SyscallReq | OverflowReq)). No exception is taken while EXL=1; requests in that window are dropped, not queued.
- Priority when HasExp=1: interrupt > overflow > syscall. ExcCode: Int=0, Sys=8, Ov=12.
- Taking an exception (edge with HasExp=1):
  - EPC <= {PresentPC[31:2], 2'b00}; the faulting or interrupted instruction does not retire.
  - Status.EXL <= 1.
  - Cause.ExcCode[6:2] <= code.
  - Any simultaneous MTC0 or ERET is suppressed.
- ERET (IsCOP0 & IsEret, HasExp=0): Status.EXL <= 0 at the edge. EPC is unchanged. The PC block selects EPC in the same cycle. An interrupt still pending becomes HasExp=1 on the first cycle after ERET.
- MTC0 (IsCOP0 & Mtc0, HasExp=0):
  - Reg 12: Status <= WriteData & 32'h0000FC03 (only IM, EXL, IE writable).
  - Reg 13: Cause is read-only except bits [9:8] (software IP).
  - Reg 14: EPC <= {WriteData[31:2], 2'b00}.
  - Other addresses are ignored.
  - The write is visible to ReadData and HasExp the next cycle.
- MFC0: ReadData = Status/Cause/EPC/PRID_VALUE for 12/13/14/15, else 0. Reads return the pre-edge value.
- Software interrupts: Cause[9:8] & Status[9:8] also contribute to int_pend; those Status bits are writable (mask extends to 32'h0000FF03).
- Reset mid-handler: EXL clears and EPC returns to 0 immediately.

Optional Feature:
- Macro CP0_COUNT_COMPARE_EN.
- When defined:
  - Adds Count(9) and Compare(11).
  - Count increments by 1 every cycle and wraps at 2^32.
  - MTC0 to 9 or 11 loads the register. A Count write takes priority over the increment in the same cycle.
  - When Count==Compare, timer-pending (TI) sets and stays set.
  - TI is ORed into Cause.IP[15] and is cleared only by an MTC0 to Compare.
  - ReadData returns Count/Compare for 9/11.
  - Both reset to 0. Count==Compare==0 at reset does not set TI until the first increment cycle compares.
- When undefined: no Count/Compare storage; addresses 9/11 read 0 and writes are ignored; IP[15] comes only from ext_int[5].

Test Plan:
- Syscall: reset; PresentPC=32'h00400010, SyscallReq=1 → HasExp=1 that cycle; after the edge EPC=32'h00400010, Cause[6:2]=8, Status[1]=1.
- ERET: from the syscall state, IsCOP0=1, IsEret=1, PresentPC=32'h00400080 → HasExp=0, EPC output=32'h00400010; after the edge Status[1]=0.
- Synchronized interrupt: ext_int=6'b000001 held → HasExp rises exactly SYNC_STAGES+1 edges later with ExcCode=0. With Status IM bit10 cleared by MTC0 12 = 32'h0000F801, HasExp never asserts.
- Masking while EXL=1: OverflowReq=1 while EXL=1 → HasExp=0, EPC unchanged. Same cycle with MTC0 14 = 32'h12345677 → EPC=32'h12345674 next cycle.
- Priority: ext_int pending, OverflowReq=1 and Mtc0 to Status all in one cycle → ExcCode=0 and Status only gains EXL (the MTC0 is suppressed).
- With CP0_COUNT_COMPARE_EN defined: MTC0 11 = 32'd20 at Count≈0 → HasExp rises once Count reaches 20; MTC0 11 = 32'd100 inside the handler clears IP[15].

Source files
------------

// File: rtl/cp0_if.sv
// Core <-> CP0 signal bundle: COP0 access, exception sources, and redirect/readback outputs.
interface cp0_if;
  logic        IsCOP0;
  logic        Mtc0;
  logic        IsEret;
  logic [4:0]  RegAddr;
  logic [31:0] WriteData;
  logic [31:0] PresentPC;
  logic        SyscallReq;
  logic        OverflowReq;
  logic [5:0]  ext_int;
  logic        HasExp;
  logic [31:0] EPC;
  logic [31:0] ReadData;
  logic [31:0] Status;
  logic [31:0] Cause;

  modport master (
    output IsCOP0, Mtc0, IsEret, RegAddr, WriteData, PresentPC,
           SyscallReq, OverflowReq, ext_int,
    input  HasExp, EPC, ReadData, Status, Cause
  );

  modport slave (
    input  IsCOP0, Mtc0, IsEret, RegAddr, WriteData, PresentPC,
           SyscallReq, OverflowReq, ext_int,
    output HasExp, EPC, ReadData, Status, Cause
  );
endinterface

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 for the single-cycle MIPS core: Status/Cause/EPC/PRId, exception entry and ERET.
// Optional Count/Compare timer enabled by defining CP0_COUNT_COMPARE_EN.
module cp0_exception_unit #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [31:0] PRID_VALUE   = 32'h0001_8000,
  parameter logic [31:0] STATUS_RESET = 32'h0000_FC01
) (
  input  logic  clk,
  input  logic  rst,
  cp0_if.slave  bus
);

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_OV  = 5'd12
  } exc_code_e;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q,  cause_d;
  logic [31:0] epc_q,    epc_d;
  logic [5:0]  sync_q [SYNC_STAGES];
  logic [5:0]  ext_sync;
  logic [5:0]  ip_next;
  logic        ti;
  logic        int_pend;
  logic        has_exp;
  logic        cop_wr;
  logic        cop_eret;
  exc_code_e   exc_code;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^bus.PresentPC[1:0];

  // Level-sensitive lines are only ever sampled; Cause.IP simply tracks the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.ext_int;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ext_sync = sync_q[SYNC_STAGES-1];

`ifdef CP0_COUNT_COMPARE_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti_q;
  logic        armed_q;

  // armed_q keeps the 0==0 reset state from raising TI before the first increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (cop_wr && bus.RegAddr == 5'd9) count_q <= bus.WriteData;
      else                               count_q <= count_q + 32'd1;
      if (cop_wr && bus.RegAddr == 5'd11) begin
        compare_q <= bus.WriteData;
        ti_q      <= 1'b0;
      end else if (armed_q && count_q == compare_q) begin
        ti_q <= 1'b1;
      end
    end
  end

  assign ti = ti_q;
`else
  assign ti = 1'b0;
`endif

  assign ip_next = ext_sync | {ti, 5'b0};

  assign int_pend = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));
  assign has_exp  = int_pend | (~status_q[1] & (bus.SyscallReq | bus.OverflowReq));
  assign cop_wr   = bus.IsCOP0 & bus.Mtc0   & ~has_exp;
  assign cop_eret = bus.IsCOP0 & bus.IsEret & ~has_exp;

  always_comb begin
    if (int_pend)             exc_code = EXC_INT;
    else if (bus.OverflowReq) exc_code = EXC_OV;
    else                      exc_code = EXC_SYS;
  end

  always_comb begin
    status_d        = status_q;
    cause_d         = cause_q;
    epc_d           = epc_q;
    cause_d[15:10]  = ip_next;
    if (has_exp) begin
      epc_d         = {bus.PresentPC[31:2], 2'b00};
      status_d[1]   = 1'b1;
      cause_d[6:2]  = exc_code;
    end else begin
      if (cop_wr) begin
        case (bus.RegAddr)
          5'd12:   status_d     = bus.WriteData & STATUS_WMASK;
          5'd13:   cause_d[9:8] = bus.WriteData[9:8];
          5'd14:   epc_d        = {bus.WriteData[31:2], 2'b00};
          default: ;
        endcase
      end
      if (cop_eret) status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= STATUS_RESET;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    case (bus.RegAddr)
      5'd12:   bus.ReadData = status_q;
      5'd13:   bus.ReadData = cause_q;
      5'd14:   bus.ReadData = epc_q;
      5'd15:   bus.ReadData = PRID_VALUE;
`ifdef CP0_COUNT_COMPARE_EN
      5'd9:    bus.ReadData = count_q;
      5'd11:   bus.ReadData = compare_q;
`endif
      default: bus.ReadData = '0;
    endcase
  end

  assign bus.HasExp = has_exp;
  assign bus.EPC    = epc_q;
  assign bus.Status = status_q;
  assign bus.Cause  = cause_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed self-checking bench for cp0_exception_unit (default build, SYNC_STAGES=2).
module tb_cp0_exception_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cp0_if bus ();

  cp0_exception_unit #(
    .SYNC_STAGES  (2),
    .PRID_VALUE   (32'h0001_8000),
    .STATUS_RESET (32'h0000_FC01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    bus.IsCOP0      = 1'b0;
    bus.Mtc0        = 1'b0;
    bus.IsEret      = 1'b0;
    bus.RegAddr     = 5'd0;
    bus.WriteData   = 32'h0;
    bus.SyscallReq  = 1'b0;
    bus.OverflowReq = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.IsCOP0    = 1'b1;
    bus.Mtc0      = 1'b1;
    bus.RegAddr   = addr;
    bus.WriteData = data;
  endtask

  task automatic eret();
    bus.IsCOP0 = 1'b1;
    bus.IsEret = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_ctl();
    bus.PresentPC = 32'h0;
    bus.ext_int   = 6'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_status", bus.Status, 32'h0000_FC01);
    check("rst_cause",  bus.Cause,  32'h0);
    check("rst_epc",    bus.EPC,    32'h0);
    check("rst_hasexp", {31'b0, bus.HasExp}, 32'h0);
    rst = 1'b0;
    tick();
    check("idle_hasexp", {31'b0, bus.HasExp}, 32'h0);

    // Syscall
    bus.PresentPC  = 32'h0040_0010;
    bus.SyscallReq = 1'b1;
    #1 check("sys_hasexp", {31'b0, bus.HasExp}, 32'h1);
    tick();
    check("sys_epc",    bus.EPC,    32'h0040_0010);
    check("sys_cause",  bus.Cause,  32'h0000_0020);
    check("sys_status", bus.Status, 32'h0000_FC03);
    check("sys_exl_drop", {31'b0, bus.HasExp}, 32'h0);
    bus.RegAddr = 5'd14;
    #1 check("mfc0_epc", bus.ReadData, 32'h0040_0010);
    clear_ctl();

    // ERET
    eret();
    bus.PresentPC = 32'h0040_0080;
    #1 check("eret_hasexp", {31'b0, bus.HasExp}, 32'h0);
    check("eret_epc_out", bus.EPC, 32'h0040_0010);
    tick();
    clear_ctl();
    check("eret_status", bus.Status, 32'h0000_FC01);
    check("eret_epc_kept", bus.EPC, 32'h0040_0010);

    // Overflow from a misaligned PC
    bus.PresentPC   = 32'h0040_0023;
    bus.OverflowReq = 1'b1;
    #1 check("ov_hasexp", {31'b0, bus.HasExp}, 32'h1);
    tick();
    clear_ctl();
    check("ov_epc",   bus.EPC,   32'h0040_0020);
    check("ov_cause", bus.Cause, 32'h0000_0030);
    eret();
    tick();
    clear_ctl();
    check("ov_eret_status", bus.Status, 32'h0000_FC01);

    // MFC0 reads
    bus.RegAddr = 5'd15;
    #1 check("mfc0_prid", bus.ReadData, 32'h0001_8000);
    bus.RegAddr = 5'd12;
    #1 check("mfc0_status", bus.ReadData, 32'h0000_FC01);
    bus.RegAddr = 5'd3;
    #1 check("mfc0_other", bus.ReadData, 32'h0);
    clear_ctl();

    // Interrupt latency through the synchronizer: SYNC_STAGES+1 edges
    bus.ext_int   = 6'b000001;
    bus.PresentPC = 32'h0040_0100;
    tick();
    check("int_e1", {31'b0, bus.HasExp}, 32'h0);
    tick();
    check("int_e2", {31'b0, bus.HasExp}, 32'h0);
    tick();
    check("int_e3", {31'b0, bus.HasExp}, 32'h1);
    check("int_e3_cause", bus.Cause, 32'h0000_0430);
    tick();
    check("int_epc",    bus.EPC,    32'h0040_0100);
    check("int_cause",  bus.Cause,  32'h0000_0400);
    check("int_status", bus.Status, 32'h0000_FC03);
    check("int_in_handler", {31'b0, bus.HasExp}, 32'h0);

    // ERET with the interrupt still pending
    eret();
    #1 check("eret_pend_same", {31'b0, bus.HasExp}, 32'h0);
    tick();
    clear_ctl();
    check("eret_pend_status", bus.Status, 32'h0000_FC01);
    check("eret_pend_next", {31'b0, bus.HasExp}, 32'h1);
    bus.PresentPC = 32'h0040_0200;
    tick();
    check("reint_epc",    bus.EPC,    32'h0040_0200);
    check("reint_status", bus.Status, 32'h0000_FC03);
    bus.ext_int = 6'b0;
    tick();
    tick();
    tick();
    check("ip_cleared", bus.Cause, 32'h0);
    eret();
    tick();
    clear_ctl();
    check("quiet_status", bus.Status, 32'h0000_FC01);
    check("quiet_hasexp", {31'b0, bus.HasExp}, 32'h0);

    // IM bit10 masked: interrupt never taken
    mtc0(5'd12, 32'h0000_F801);
    tick();
    clear_ctl();
    check("mask_status", bus.Status, 32'h0000_F801);
    bus.ext_int = 6'b000001;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mask_hasexp", {31'b0, bus.HasExp}, 32'h0);
    end
    check("mask_cause", bus.Cause, 32'h0000_0400);

    // Unmask: write takes effect the following cycle
    mtc0(5'd12, 32'h0000_FC01);
    #1 check("unmask_same", {31'b0, bus.HasExp}, 32'h0);
    tick();
    clear_ctl();
    check("unmask_status", bus.Status, 32'h0000_FC01);
    check("unmask_next", {31'b0, bus.HasExp}, 32'h1);

    // Priority: interrupt beats overflow, MTC0 suppressed
    bus.OverflowReq = 1'b1;
    mtc0(5'd12, 32'h0);
    bus.PresentPC = 32'h0040_0300;
    #1 check("prio_hasexp", {31'b0, bus.HasExp}, 32'h1);
    tick();
    clear_ctl();
    check("prio_cause",  bus.Cause,  32'h0000_0400);
    check("prio_status", bus.Status, 32'h0000_FC03);
    check("prio_epc",    bus.EPC,    32'h0040_0300);

    // Requests dropped while EXL=1; MTC0 EPC still lands
    bus.ext_int     = 6'b0;
    bus.OverflowReq = 1'b1;
    mtc0(5'd14, 32'h1234_5677);
    #1 check("exl_hasexp", {31'b0, bus.HasExp}, 32'h0);
    tick();
    clear_ctl();
    check("exl_epc",    bus.EPC,    32'h1234_5674);
    check("exl_status", bus.Status, 32'h0000_FC03);
    check("exl_cause",  bus.Cause,  32'h0000_0400);
    bus.RegAddr = 5'd14;
    #1 check("exl_mfc0_epc", bus.ReadData, 32'h1234_5674);
    clear_ctl();

    // Software interrupts via Cause[9:8] / Status[9:8]
    tick();
    tick();
    check("sw_ip_clear", bus.Cause, 32'h0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    tick();
    clear_ctl();
    check("sw_cause", bus.Cause, 32'h0000_0300);
    check("sw_hasexp_masked", {31'b0, bus.HasExp}, 32'h0);
    mtc0(5'd12, 32'h0000_FF01);
    tick();
    clear_ctl();
    check("sw_status", bus.Status, 32'h0000_FF01);
    check("sw_hasexp", {31'b0, bus.HasExp}, 32'h1);
    bus.PresentPC = 32'h0040_0400;
    tick();
    check("sw_epc",    bus.EPC,    32'h0040_0400);
    check("sw_status_exl", bus.Status, 32'h0000_FF03);
    check("sw_cause_code", bus.Cause, 32'h0000_0300);

    // Asynchronous reset inside the handler
    #3 rst = 1'b1;
    #1;
    check("arst_status", bus.Status, 32'h0000_FC01);
    check("arst_epc",    bus.EPC,    32'h0);
    check("arst_cause",  bus.Cause,  32'h0);
    check("arst_hasexp", {31'b0, bus.HasExp}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_hasexp", {31'b0, bus.HasExp}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
